// File: rtl/tx_chksum_share_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tx_chksum_share_arb : round-robin share of one TX checksum engine with   |
// | in-order result steering. Revision 1.0                                   |
// +--------------------------------------------------------------------------+
module tx_chksum_share_arb #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_WIDTH  = 256,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int USER_WIDTH  = 64,
  parameter int ORDER_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  // requester command side
  input  logic [NUM_REQ-1:0]             i_src_cmd_val,
  output logic [NUM_REQ-1:0]             o_src_cmd_rdy,
  input  logic [NUM_REQ-1:0]             i_src_cmd_csum_enable,
  input  logic [NUM_REQ*8-1:0]           i_src_cmd_csum_start,
  input  logic [NUM_REQ*8-1:0]           i_src_cmd_csum_offset,
  input  logic [NUM_REQ*16-1:0]          i_src_cmd_csum_init,
  // requester data side
  input  logic [NUM_REQ-1:0]             i_src_tval,
  output logic [NUM_REQ-1:0]             o_src_trdy,
  input  logic [NUM_REQ-1:0]             i_src_tlast,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_src_tdata,
  input  logic [NUM_REQ*KEEP_WIDTH-1:0]  i_src_tkeep,
  input  logic [NUM_REQ*USER_WIDTH-1:0]  i_src_tuser,
  // engine command
  output logic                           o_eng_cmd_val,
  input  logic                           i_eng_cmd_rdy,
  output logic                           o_eng_cmd_csum_enable,
  output logic [7:0]                     o_eng_cmd_csum_start,
  output logic [7:0]                     o_eng_cmd_csum_offset,
  output logic [15:0]                    o_eng_cmd_csum_init,
  // engine data input
  output logic [DATA_WIDTH-1:0]          o_eng_tdata,
  output logic [KEEP_WIDTH-1:0]          o_eng_tkeep,
  output logic [USER_WIDTH-1:0]          o_eng_tuser,
  output logic                           o_eng_tval,
  output logic                           o_eng_tlast,
  input  logic                           i_eng_trdy,
  // engine result stream
  input  logic [DATA_WIDTH-1:0]          i_eng_res_tdata,
  input  logic [KEEP_WIDTH-1:0]          i_eng_res_tkeep,
  input  logic [USER_WIDTH-1:0]          i_eng_res_tuser,
  input  logic                           i_eng_res_tval,
  input  logic                           i_eng_res_tlast,
  output logic                           o_eng_res_trdy,
  // consumers
  output logic [NUM_REQ-1:0]             o_dst_tval,
  output logic [NUM_REQ-1:0]             o_dst_tlast,
  input  logic [NUM_REQ-1:0]             i_dst_trdy,
  output logic [DATA_WIDTH-1:0]          o_dst_tdata,
  output logic [KEEP_WIDTH-1:0]          o_dst_tkeep,
  output logic [USER_WIDTH-1:0]          o_dst_tuser
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(ORDER_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  state_t               r_state;
  logic [ID_W-1:0]      r_grant;
  logic [ID_W-1:0]      r_rr_ptr;
  logic [ID_W-1:0]      r_fifo [ORDER_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  logic [ID_W-1:0]      w_winner;
  logic                 w_any;
  logic                 w_full;
  logic                 w_empty;
  logic [ID_W-1:0]      w_head;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_last_fire;

  // (base + off) mod NUM_REQ; both operands are already below NUM_REQ
  function automatic logic [ID_W-1:0] f_wrap_add(input logic [ID_W-1:0] base, input int off);
    logic [ID_W:0] s;
    s = {1'b0, base} + (ID_W+1)'(off);
    if (s >= (ID_W+1)'(NUM_REQ)) s = s - (ID_W+1)'(NUM_REQ);
    return s[ID_W-1:0];
  endfunction

  assign w_full  = (r_count == c_full_cnt);
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rd_ptr];

  // Scan from the farthest candidate back to rr_ptr so the nearest one wins.
  always_comb begin
    w_winner = r_rr_ptr;
    w_any    = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_src_cmd_val[f_wrap_add(r_rr_ptr, i)]) begin
        w_winner = f_wrap_add(r_rr_ptr, i);
        w_any    = 1'b1;
      end
    end
  end

  always_comb begin
    o_eng_cmd_val         = 1'b0;
    o_src_cmd_rdy         = '0;
    o_eng_cmd_csum_enable = 1'b0;
    o_eng_cmd_csum_start  = '0;
    o_eng_cmd_csum_offset = '0;
    o_eng_cmd_csum_init   = '0;
    if (!rst && (r_state == ST_IDLE) && w_any && !w_full) begin
      o_eng_cmd_val           = 1'b1;
      o_src_cmd_rdy[w_winner] = i_eng_cmd_rdy;
      o_eng_cmd_csum_enable   = i_src_cmd_csum_enable[w_winner];
      o_eng_cmd_csum_start    = i_src_cmd_csum_start[32'(w_winner)*8 +: 8];
      o_eng_cmd_csum_offset   = i_src_cmd_csum_offset[32'(w_winner)*8 +: 8];
      o_eng_cmd_csum_init     = i_src_cmd_csum_init[32'(w_winner)*16 +: 16];
    end
  end

  always_comb begin
    o_eng_tval  = 1'b0;
    o_eng_tlast = 1'b0;
    o_eng_tdata = '0;
    o_eng_tkeep = '0;
    o_eng_tuser = '0;
    o_src_trdy  = '0;
    if (!rst && (r_state == ST_DATA)) begin
      o_eng_tval          = i_src_tval[r_grant];
      o_eng_tlast         = i_src_tlast[r_grant];
      o_eng_tdata         = i_src_tdata[32'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
      o_eng_tkeep         = i_src_tkeep[32'(r_grant)*KEEP_WIDTH +: KEEP_WIDTH];
      o_eng_tuser         = i_src_tuser[32'(r_grant)*USER_WIDTH +: USER_WIDTH];
      o_src_trdy[r_grant] = i_eng_trdy;
    end
  end

  always_comb begin
    o_dst_tval     = '0;
    o_dst_tlast    = '0;
    o_eng_res_trdy = 1'b0;
    o_dst_tdata    = '0;
    o_dst_tkeep    = '0;
    o_dst_tuser    = '0;
    if (!rst && !w_empty) begin
      o_dst_tval[w_head]  = i_eng_res_tval;
      o_dst_tlast[w_head] = i_eng_res_tlast;
      o_eng_res_trdy      = i_dst_trdy[w_head];
      o_dst_tdata         = i_eng_res_tdata;
      o_dst_tkeep         = i_eng_res_tkeep;
      o_dst_tuser         = i_eng_res_tuser;
    end
  end

  assign w_push      = o_eng_cmd_val & i_eng_cmd_rdy;
  assign w_pop       = i_eng_res_tval & o_eng_res_trdy & i_eng_res_tlast;
  assign w_last_fire = o_eng_tval & i_eng_trdy & o_eng_tlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_push) begin
            r_grant <= w_winner;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_last_fire) begin
            r_rr_ptr <= f_wrap_add(r_grant, 1);
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < ORDER_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_winner;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  a_res_while_empty: assert property (@(posedge clk) disable iff (rst) i_eng_res_tval |-> !w_empty);
  a_no_overflow:     assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));
  a_no_underflow:    assert property (@(posedge clk) disable iff (rst) !(w_pop && w_empty));

endmodule
`default_nettype wire
